// File: rtl/tour_distance_calc.sv
// Tour-length evaluator: walks adjacent node pairs of a latched tour, looks up
// each edge in an external registered distance ROM and sums with saturation.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one pair address per cycle, index 0..P-1
// DRAIN | accumulating the ROM word of the last issued pair
// DONE  | one-cycle result strobe; start here begins the next tour
module tour_distance_calc #(
    parameter int NUM_NODES   = 8,
    parameter int NODE_W      = 5,
    parameter int DIST_W      = 9,
    parameter int SUM_W       = 12,
    parameter int CLOSED_LOOP = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_NODES*NODE_W-1:0]   tour,
    output logic [2*NODE_W-1:0]           rom_addr,
    input  logic [DIST_W-1:0]             rom_dout,
    output logic                          busy,
    output logic                          done,
    output logic [SUM_W-1:0]              distance,
    output logic                          overflow
);

    localparam int PAIRS = NUM_NODES - 1 + CLOSED_LOOP;
    localparam int IDX_W = (NUM_NODES > 2) ? $clog2(NUM_NODES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);
    localparam logic [IDX_W-1:0] WRAP_IDX = IDX_W'(NUM_NODES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        state, state_nxt;
    logic [NUM_NODES*NODE_W-1:0]   tour_q;
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              idx_b;
    logic                          vld;
    logic [SUM_W-1:0]              acc;
    logic                          ovf;
    logic                          accept;
    logic [NODE_W-1:0]             nodes [NUM_NODES];
    logic [NODE_W-1:0]             node_a;
    logic [NODE_W-1:0]             node_b;
    logic [SUM_W:0]                sum_ext;

    for (genvar i = 0; i < NUM_NODES; i++) begin : g_unpack
        assign nodes[i] = tour_q[i*NODE_W +: NODE_W];
    end

    // The second node of a pair wraps to node 0 only for the closing edge.
    assign idx_b  = (idx == WRAP_IDX) ? '0 : idx + IDX_W'(1);
    assign node_a = nodes[idx];
    assign node_b = nodes[idx_b];

    always_comb begin
        rom_addr = {node_a, node_b};
        if (node_b < node_a) begin
            rom_addr = {node_b, node_a};
        end
    end

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign sum_ext = {1'b0, acc} + (SUM_W+1)'(rom_dout);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tour_q <= '0;
            idx    <= '0;
            vld    <= 1'b0;
            acc    <= '0;
            ovf    <= 1'b0;
        end else begin
            // ROM data lags its address by one cycle, so vld trails issue.
            vld <= (state == RUN);
            if (accept) begin
                tour_q <= tour;
                idx    <= '0;
                acc    <= '0;
                ovf    <= 1'b0;
            end else begin
                if ((state == RUN) && (idx != LAST_IDX)) begin
                    idx <= idx + IDX_W'(1);
                end
                if (vld) begin
                    if (sum_ext[SUM_W]) begin
                        acc <= '1;
                        ovf <= 1'b1;
                    end else begin
                        acc <= sum_ext[SUM_W-1:0];
                    end
                end
            end
        end
    end

    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign distance = acc;
    assign overflow = ovf;

endmodule

// File: tb/tb_tour_distance_calc.sv
// Directed bench: open-loop, closed-loop and narrow-sum instances share start
// and tour; each has its own registered ROM model.
module tb_tour_distance_calc;

    localparam logic [39:0] T0 = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [39:0] T1 = {5'd6, 5'd5, 5'd4, 5'd2, 5'd1, 5'd0, 5'd3, 5'd7};
    localparam logic [39:0] T2 = {5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [39:0] tour;
    logic [8:0]  sat_val;

    logic [9:0]  addr_o, addr_c, addr_s;
    logic [8:0]  rom_o, rom_c, rom_s;
    logic        busy_o, busy_c, busy_s;
    logic        done_o, done_c, done_s;
    logic [11:0] dist_o, dist_c;
    logic [9:0]  dist_s;
    logic        ovf_o, ovf_c, ovf_s;

    int vectors = 0;
    int miscompares = 0;

    int          d_open [2];
    int          ndone_open;
    int          d_closed;
    int          busy_cnt;
    int          done_cnt;
    logic [9:0]  addr_first_open;
    logic [9:0]  addr_last_closed;
    logic [11:0] dist_open_at [2];
    logic [11:0] dist_closed_at;
    logic [9:0]  dist_sat_at;
    logic        ovf_open_at;
    logic        ovf_sat_at;

    always #5 clk = ~clk;

    tour_distance_calc u_open (
        .clk(clk), .rst_n(rst_n), .start(start), .tour(tour),
        .rom_addr(addr_o), .rom_dout(rom_o), .busy(busy_o), .done(done_o),
        .distance(dist_o), .overflow(ovf_o)
    );

    tour_distance_calc #(.CLOSED_LOOP(1)) u_closed (
        .clk(clk), .rst_n(rst_n), .start(start), .tour(tour),
        .rom_addr(addr_c), .rom_dout(rom_c), .busy(busy_c), .done(done_c),
        .distance(dist_c), .overflow(ovf_c)
    );

    tour_distance_calc #(.SUM_W(10)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .tour(tour),
        .rom_addr(addr_s), .rom_dout(rom_s), .busy(busy_s), .done(done_s),
        .distance(dist_s), .overflow(ovf_s)
    );

    // Registered ROMs: distance(a,b) = a+b, saturation instance returns sat_val.
    always_ff @(posedge clk) begin
        rom_o <= 9'(addr_o[9:5]) + 9'(addr_o[4:0]);
        rom_c <= 9'(addr_c[9:5]) + 9'(addr_c[4:0]);
        rom_s <= sat_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle n is the cycle after the nth edge following the accepting edge.
    task automatic go(input logic [39:0] tv, input int start_off_n, input int pulse_n,
                      input int swap_n, input logic [39:0] tv2, input int len);
        ndone_open = 0;
        d_open[0]  = -1;
        d_open[1]  = -1;
        d_closed   = -1;
        busy_cnt   = 0;
        @(posedge clk); #1;
        start = 1'b1;
        tour  = tv;
        @(posedge clk); #1;
        for (int n = 0; n < len; n++) begin
            if (busy_o) busy_cnt++;
            if (n == 0) addr_first_open = addr_o;
            if (n == 7) addr_last_closed = addr_c;
            if (done_o) begin
                if (ndone_open < 2) begin
                    d_open[ndone_open]       = n;
                    dist_open_at[ndone_open] = dist_o;
                end
                ndone_open++;
                ovf_open_at = ovf_o;
                dist_sat_at = dist_s;
                ovf_sat_at  = ovf_s;
            end
            if (done_c && d_closed < 0) begin
                d_closed       = n;
                dist_closed_at = dist_c;
            end
            start = (n < start_off_n) || (n == pulse_n);
            if (n == swap_n) tour = tv2;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        tour    = '0;
        sat_val = 9'd511;
        #12;
        rst_n = 1'b1;
        #1;
        chk("reset_distance", 32'(dist_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_overflow", 32'(ovf_o), 32'd0);
        chk("reset_rom_addr", 32'(addr_o), 32'd0);

        // Ascending tour; saturation instance sees 511 per edge.
        go(T0, 0, -1, -1, T0, 14);
        chk("open_done_cycle", 32'(d_open[0]), 32'd8);
        chk("open_done_count", 32'(ndone_open), 32'd1);
        chk("open_distance", 32'(dist_open_at[0]), 32'd49);
        chk("open_overflow", 32'(ovf_open_at), 32'd0);
        chk("open_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("open_distance_hold", 32'(dist_o), 32'd49);
        chk("closed_done_cycle", 32'(d_closed), 32'd9);
        chk("closed_distance", 32'(dist_closed_at), 32'd56);
        chk("closed_last_addr", 32'(addr_last_closed), 32'h007);
        chk("sat_distance", 32'(dist_sat_at), 32'd1023);
        chk("sat_overflow", 32'(ovf_sat_at), 32'd1);

        // Descending first pair; saturation instance recovers with ROM = 1.
        sat_val = 9'd1;
        go(T1, 0, -1, -1, T1, 14);
        chk("order_first_addr", 32'(addr_first_open), 32'h067);
        chk("order_distance", 32'(dist_open_at[0]), 32'd43);
        chk("order_closed_distance", 32'(dist_closed_at), 32'd56);
        chk("recover_distance", 32'(dist_sat_at), 32'd7);
        chk("recover_overflow", 32'(ovf_sat_at), 32'd0);

        // Back-to-back with start held and tour changed mid-run.
        go(T0, 10, -1, 3, T2, 22);
        chk("b2b_done_count", 32'(ndone_open), 32'd2);
        chk("b2b_first_done", 32'(d_open[0]), 32'd8);
        chk("b2b_second_done", 32'(d_open[1]), 32'd17);
        chk("b2b_first_distance", 32'(dist_open_at[0]), 32'd49);
        chk("b2b_second_distance", 32'(dist_open_at[1]), 32'd28);

        // Single start pulse during RUN must be ignored.
        go(T1, 0, 3, -1, T1, 20);
        chk("pulse_done_count", 32'(ndone_open), 32'd1);
        chk("pulse_done_cycle", 32'(d_open[0]), 32'd8);
        chk("pulse_distance", 32'(dist_open_at[0]), 32'd43);

        // Reset three cycles into a run aborts it.
        @(posedge clk); #1;
        start = 1'b1;
        tour  = T0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_partial_sum", 32'(dist_o), 32'd4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_distance", 32'(dist_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_closed_distance", 32'(dist_c), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_o) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        go(T0, 0, -1, -1, T0, 12);
        chk("post_reset_done_cycle", 32'(d_open[0]), 32'd8);
        chk("post_reset_distance", 32'(dist_open_at[0]), 32'd49);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tour_distance_calc.md
# tour_distance_calc

Parametrised tour-length evaluator for the genetic TSP datapath. It latches a packed tour of `NUM_NODES` node IDs and walks each adjacent pair, optionally including the closing edge from the last node back to the first. For each pair it looks up the pairwise distance in an external synchronous distance ROM, and accumulates the total into a saturating sum. It sits between the population memory and the fitness/selection stage. It issues one ROM lookup per cycle, so throughput is one edge per clock.

## Interface

Parameters:
- `NUM_NODES`, default 8: nodes per tour; must be ≥ 2.
- `NODE_W`, default 5: node ID width.
- `DIST_W`, default 9: ROM distance word width.
- `SUM_W`, default 12: accumulator and result width.
- `CLOSED_LOOP`, default 0: 1 adds the edge from the last node back to node 0.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE or DONE.
- `tour` input `NUM_NODES*NODE_W`: node i is at `[i*NODE_W +: NODE_W]`; captured on the accepting edge.
- `rom_addr` output `2*NODE_W`: `{min(a,b), max(a,b)}` for the current pair.
- `rom_dout` input `DIST_W`: ROM data, registered inside the ROM, valid one cycle after `rom_addr`.
- `busy` output 1: high from acceptance until `done`.
- `done` output 1: single-cycle pulse; `distance` is valid.
- `distance` output `SUM_W`: tour length; holds until the next accepted start.
- `overflow` output 1: sticky saturation flag for the current tour.

## Operation

- P = `NUM_NODES`−1+`CLOSED_LOOP` pairs.
- Pair k, for k < `NUM_NODES`−1, is (node k, node k+1). If `CLOSED_LOOP`=1, pair P−1 is (node `NUM_NODES`−1, node 0).
- FSM states:
  - IDLE: waits for `start`.
  - RUN: issues pair addresses; the issue counter runs 0..P−1.
  - DRAIN: one cycle to accumulate the last ROM word.
  - DONE: one cycle; `done`=1.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DRAIN after pair P−1 is issued.
  - DRAIN→DONE.
  - DONE→RUN if `start`=1, otherwise DONE→IDLE.
- On acceptance:
  - latch `tour` internally, so later changes on the input are ignored;
  - clear the accumulator and `overflow`;
  - set the issue index to 0.
- Accumulation: a valid-delay flag, one cycle behind issue, qualifies `rom_dout`. `sum <= sum + rom_dout` is computed at SUM_W+1 bits.
- Saturation: if the result exceeds 2^SUM_W−1, the sum clamps to all-ones and `overflow`=1 until the next acceptance.
- `distance` is the accumulator register.
- Equal IDs in a pair produce address `{a,a}`; the ROM content decides the value and the block treats it normally.
- `rom_addr` is don't-care outside RUN, but must be driven by the combinational min/max of the current pair. It must not be X.
- `start` during RUN or DRAIN is ignored; there is no queueing.
- `busy` = (state is RUN or DRAIN).

## Timing

- Reset state (asynchronous on `rst_n`=0): state=IDLE, issue index=0, `distance`=0, `overflow`=0, `done`=0, `busy`=0, internal tour register=0.
- Reset asserted mid-tour aborts the tour immediately. There is no `done` for the aborted tour.
- Let E0 be the rising edge that samples `start`=1.
- Pair k address is presented in the cycle after edge E_k.
- Pair k is accumulated at edge E_(k+2).
- Last accumulation occurs at edge E_(P+1). `done`=1 in the cycle following E_(P+1).
- Latency from the accepting edge to `done` is P+1 cycles; default is 8.
- Back-to-back: `start` held during the DONE cycle is accepted at the edge ending DONE, giving one tour per P+2 cycles.
- `distance` and `overflow` are stable from the DONE cycle until the next acceptance edge.

## Test plan

- Bench ROM returns a+b. With defaults, tour 0,1,…,7 → `done` 8 cycles after the accepting edge; `distance`=49; `overflow`=0; `busy` high for 7+1 cycles.
- Same tour with `CLOSED_LOOP`=1 → `distance`=56, with `done` at 9 cycles. The last `rom_addr` observed is `{0,7}`=0x007.
- Address ordering: tour 7,3,… → first `rom_addr`=`{3,7}`=0x067, never `{7,3}`.
- Saturation: ROM returns 511 for all addresses and `SUM_W`=10 → `distance`=1023 and `overflow`=1. A following tour with the ROM returning 1 → `distance`=7 and `overflow`=0.
- Back-to-back: hold `start` high and change `tour` mid-run. The second result uses the tour latched at the second acceptance. `done` pulses are exactly 9 cycles apart, and a `start` pulse during RUN is ignored.
- Drop `rst_n` low three cycles into a run → outputs return to 0 immediately and no `done` occurs. After release, a new `start` yields the correct value (49).
